// File: rtl/alu_pkg.sv
// alu_pkg: ctrl encodings {funct7[5], funct3} shared by the ALU and the decoder.
package alu_pkg;
  localparam logic [3:0] ALU_ADD  = 4'b0000;
  localparam logic [3:0] ALU_SUB  = 4'b1000;
  localparam logic [3:0] ALU_SLL  = 4'b0001;
  localparam logic [3:0] ALU_SLT  = 4'b0010;
  localparam logic [3:0] ALU_SLTU = 4'b0011;
  localparam logic [3:0] ALU_XOR  = 4'b0100;
  localparam logic [3:0] ALU_SRL  = 4'b0101;
  localparam logic [3:0] ALU_SRA  = 4'b1101;
  localparam logic [3:0] ALU_OR   = 4'b0110;
  localparam logic [3:0] ALU_AND  = 4'b0111;
endpackage

// File: rtl/alu_shifter.sv
// alu_shifter: combinational 32-bit barrel shifter; dir=1 shifts right, arith sign-fills.
module alu_shifter (
  input  logic [31:0] data,
  input  logic [4:0]  shamt,
  input  logic        dir,
  input  logic        arith,
  output logic [31:0] result
);
  logic [31:0] stage [0:5];
  logic        fill;
  assign fill = arith & data[31];
  assign stage[0] = dir ? data : {<<{data}};
  for (genvar i = 0; i < 5; i++) begin : g_stage
    assign stage[i+1] = shamt[i] ? {{(1 << i){fill & dir}}, stage[i][31:(1 << i)]} : stage[i];
  end
  assign result = dir ? stage[5] : {<<{stage[5]}};
endmodule

// File: rtl/alu.sv
// alu: registered RV32I ALU with zero flag; define ALU_FLAGS_EN for carry/overflow/negative outputs.
module alu
  import alu_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  input  logic [31:0] input_a,
  input  logic [31:0] input_b,
  input  logic [3:0]  ctrl,
  output logic [31:0] out,
  output logic        is_zero,
  output logic        out_valid
`ifdef ALU_FLAGS_EN
  ,
  output logic        carry,
  output logic        overflow,
  output logic        negative
`endif
);
  logic        sub;
  logic [31:0] b_op, shifted, res;
  logic [32:0] sum;
  assign sub  = ctrl == ALU_SUB;
  assign b_op = sub ? ~input_b : input_b;
  assign sum  = {1'b0, input_a} + {1'b0, b_op} + {32'b0, sub};
  alu_shifter u_shifter (
    .data   (input_a),
    .shamt  (input_b[4:0]),
    .dir    (ctrl != ALU_SLL),
    .arith  (ctrl == ALU_SRA),
    .result (shifted)
  );
  always_comb begin
    res = '0;
    case (ctrl)
      ALU_ADD, ALU_SUB:          res = sum[31:0];
      ALU_SLL, ALU_SRL, ALU_SRA: res = shifted;
      ALU_SLT:  res = {31'b0, $signed(input_a) < $signed(input_b)};
      ALU_SLTU: res = {31'b0, input_a < input_b};
      ALU_XOR:  res = input_a ^ input_b;
      ALU_OR:   res = input_a | input_b;
      ALU_AND:  res = input_a & input_b;
      default:  res = '0;
    endcase
  end
`ifdef ALU_FLAGS_EN
  logic arith_op;
  assign arith_op = ctrl == ALU_ADD || sub;
`endif
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out       <= '0;
      is_zero   <= 1'b1;
      out_valid <= 1'b0;
`ifdef ALU_FLAGS_EN
      carry     <= 1'b0;
      overflow  <= 1'b0;
      negative  <= 1'b0;
`endif
    end else begin
      out_valid <= in_valid;
      if (in_valid) begin
        out     <= res;
        is_zero <= ~|res;
`ifdef ALU_FLAGS_EN
        carry    <= arith_op & sum[32];
        overflow <= arith_op & (input_a[31] == b_op[31]) & (sum[31] != input_a[31]);
        negative <= res[31];
`endif
      end
    end
  end
endmodule

// File: tb/tb_alu.sv
// tb_alu: self-checking bench for alu against an arithmetic reference model.
module tb_alu;
  logic        clk = 0, rst = 1, in_valid = 0;
  logic [31:0] input_a = 0, input_b = 0, out;
  logic [3:0]  ctrl = 0;
  logic        is_zero, out_valid;
  int          checks = 0, fails = 0;

  alu dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .input_a(input_a), .input_b(input_b),
    .ctrl(ctrl), .out(out), .is_zero(is_zero), .out_valid(out_valid)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] model(input logic [31:0] a, input logic [31:0] b, input logic [3:0] c);
    int unsigned s;
    s = b & 32'd31;
    case (c)
      4'b0000: return a + b;
      4'b1000: return a - b;
      4'b0001: return a << s;
      4'b0010: return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      4'b0011: return (a < b) ? 32'd1 : 32'd0;
      4'b0100: return a ^ b;
      4'b0101: return a >> s;
      4'b1101: return (a >> s) | (a[31] ? ~(32'hFFFFFFFF >> s) : 32'h0);
      4'b0110: return a | b;
      4'b0111: return a & b;
      default: return 32'h0;
    endcase
  endfunction

  task automatic drive(input logic [31:0] a, input logic [31:0] b, input logic [3:0] c, input logic v);
    @(negedge clk);
    input_a = a; input_b = b; ctrl = c; in_valid = v;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    rst = 1;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (out !== 32'h0 || is_zero !== 1'b1 || out_valid !== 1'b0) begin
      fails++;
      $display("FAIL reset_hold: out=%h is_zero=%b out_valid=%b, required 00000000 1 0", out, is_zero, out_valid);
    end
    @(negedge clk) rst = 0;
    drive(0, 0, 4'b0000, 1);
    checks++;
    if (out !== 32'h0 || is_zero !== 1'b1 || out_valid !== 1'b1) begin
      fails++;
      $display("FAIL reset_first_add: out=%h is_zero=%b out_valid=%b, required 00000000 1 1", out, is_zero, out_valid);
    end
  endtask

  task automatic test_directed;
    logic [31:0] a_t [10] = '{32'h4, 32'h0000FFFF, 32'hFFFFFFFF, 32'h5, 32'hFFFFFFFF,
                              32'h80000000, 32'h80000000, 32'h80000000, 32'h80000000, 32'h1};
    logic [31:0] b_t [10] = '{32'h8, 32'h1, 32'h1, 32'h5, 32'h1,
                              32'h21, 32'h21, 32'h21, 32'h21, 32'h21};
    logic [3:0]  c_t [10] = '{4'b1000, 4'b1000, 4'b1000, 4'b1000, 4'b0000,
                              4'b0010, 4'b0011, 4'b1101, 4'b0101, 4'b0001};
    logic [31:0] e_t [10] = '{32'hFFFFFFFC, 32'h0000FFFE, 32'hFFFFFFFE, 32'h0, 32'h0,
                              32'h1, 32'h0, 32'hC0000000, 32'h40000000, 32'h2};
    for (int i = 0; i < 10; i++) begin
      drive(a_t[i], b_t[i], c_t[i], 1);
      checks++;
      if (out !== e_t[i] || is_zero !== (e_t[i] == 0) || out_valid !== 1'b1) begin
        fails++;
        $display("FAIL directed_%0d: out=%h is_zero=%b out_valid=%b, required %h %b 1",
                 i, out, is_zero, out_valid, e_t[i], e_t[i] == 0);
      end
    end
  endtask

  task automatic test_hold;
    drive(32'h80000000, 32'h21, 4'b0101, 1);
    drive(32'h12345678, 32'h9, 4'b0000, 0);
    checks++;
    if (out !== 32'h40000000 || is_zero !== 1'b0 || out_valid !== 1'b0) begin
      fails++;
      $display("FAIL hold: out=%h is_zero=%b out_valid=%b, required 40000000 0 0", out, is_zero, out_valid);
    end
  endtask

  task automatic test_invalid_code;
    drive(32'hDEADBEEF, 32'h12345678, 4'b1111, 1);
    checks++;
    if (out !== 32'h0 || is_zero !== 1'b1 || out_valid !== 1'b1) begin
      fails++;
      $display("FAIL invalid_code: out=%h is_zero=%b out_valid=%b, required 00000000 1 1", out, is_zero, out_valid);
    end
  endtask

  task automatic test_async_reset;
    drive(32'h7, 32'h3, 4'b0110, 1);
    #2 rst = 1;
    #1;
    checks++;
    if (out !== 32'h0 || is_zero !== 1'b1 || out_valid !== 1'b0) begin
      fails++;
      $display("FAIL async_reset: out=%h is_zero=%b out_valid=%b, required 00000000 1 0", out, is_zero, out_valid);
    end
    @(negedge clk) rst = 0;
    drive(32'h7, 32'h3, 4'b0111, 1);
    checks++;
    if (out !== 32'h3 || is_zero !== 1'b0 || out_valid !== 1'b1) begin
      fails++;
      $display("FAIL after_reset_load: out=%h is_zero=%b out_valid=%b, required 00000003 0 1", out, is_zero, out_valid);
    end
  endtask

  task automatic test_back_to_back;
    logic [31:0] exp_out = out, a, b;
    logic [3:0]  c;
    logic        v;
    for (int i = 0; i < 300; i++) begin
      a = $urandom;
      b = (i % 3 == 0) ? $urandom_range(0, 40) : $urandom;
      c = 4'($urandom);
      v = $urandom_range(0, 3) != 0;
      if (v) exp_out = model(a, b, c);
      drive(a, b, c, v);
      checks++;
      if (out !== exp_out || is_zero !== (exp_out == 0) || out_valid !== v) begin
        fails++;
        $display("FAIL random_%0d a=%h b=%h ctrl=%b v=%b: out=%h is_zero=%b out_valid=%b, required %h %b %b",
                 i, a, b, c, v, out, is_zero, out_valid, exp_out, exp_out == 0, v);
      end
    end
  endtask

  initial begin
    test_reset;
    test_directed;
    test_hold;
    test_invalid_code;
    test_async_reset;
    test_back_to_back;
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
